// File: rtl/reaction_timer_if.sv
// Game-side bundle between the reaction timer and its neighbours: round
// control and key in, stimulus lamp and BCD result with end strobe out.
interface reaction_timer_if;
  logic        restart;
  logic        key;
  logic        led;
  logic        det_end;
  logic [15:0] ctrl;
  logic        foul;
  logic        timeout;

  modport slave  (input  restart, key, output led, det_end, ctrl, foul, timeout);
  modport master (output restart, key, input  led, det_end, ctrl, foul, timeout);
endinterface

// File: rtl/reaction_timer.sv
// Reaction-test front end: random pre-stimulus delay, millisecond BCD
// reaction count, false-start and timeout detection.
module reaction_timer #(
  parameter int          MS_DIV       = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 12,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  reaction_timer_if.slave  bus
);
  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS) + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

  typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FOUL} state_t;

  state_t          state_q;
  logic            key_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [PW-1:0]   presc_q;
  logic [DW-1:0]   dly_q, dly_d;
  logic [15:0]     ctrl_q, ctrl_inc;
  logic            led_q, det_end_q, foul_q, timeout_q;
  logic            press, ms_tick, carry;

  assign press   = bus.key & ~key_q;
  assign ms_tick = (presc_q == PRESC_MAX);
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign dly_d   = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);

  // Ripple-carry BCD increment; digits that roll 9->0 pass the carry upward.
  always_comb begin
    ctrl_inc = ctrl_q;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (ctrl_q[4*i +: 4] == 4'd9) begin
          ctrl_inc[4*i +: 4] = 4'd0;
        end else begin
          ctrl_inc[4*i +: 4] = ctrl_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      presc_q   <= '0;
      dly_q     <= '0;
      ctrl_q    <= '0;
      led_q     <= 1'b0;
      det_end_q <= 1'b0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      key_q     <= bus.key;
      lfsr_q    <= lfsr_d;
      det_end_q <= 1'b0;
      if (bus.restart) begin
        state_q   <= WAIT;
        ctrl_q    <= '0;
        led_q     <= 1'b0;
        foul_q    <= 1'b0;
        timeout_q <= 1'b0;
        presc_q   <= '0;
        dly_q     <= dly_d;
      end else begin
        case (state_q)
          WAIT: begin
            presc_q <= ms_tick ? '0 : presc_q + 1'b1;
            if (ms_tick) dly_q <= dly_q - 1'b1;
            // A press on the final tick still counts as a false start.
            if (press) begin
              state_q   <= FOUL;
              foul_q    <= 1'b1;
              det_end_q <= 1'b1;
            end else if (ms_tick && dly_q == DW'(1)) begin
              state_q <= GO;
              led_q   <= 1'b1;
            end
          end
          GO: begin
            presc_q <= ms_tick ? '0 : presc_q + 1'b1;
            if (press) begin
              state_q   <= DONE;
              led_q     <= 1'b0;
              det_end_q <= 1'b1;
            end else if (ms_tick) begin
              if (ctrl_q == 16'h9999) begin
                state_q   <= DONE;
                led_q     <= 1'b0;
                det_end_q <= 1'b1;
                timeout_q <= 1'b1;
              end else begin
                ctrl_q <= ctrl_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.led     = led_q;
  assign bus.det_end = det_end_q;
  assign bus.ctrl    = ctrl_q;
  assign bus.foul    = foul_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_reaction_timer.sv
// Randomized bench for reaction_timer against a millisecond-level model of
// the round: delay from the LFSR sequence, result = whole ms before the press.
module tb_reaction_timer;
  localparam int MS  = 4;
  localparam int MIN = 2;
  localparam int RB  = 2;
  localparam int TO_STEPS = 10000 * MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_delay;
  logic [15:0] m_lfsr;
  logic [15:0] c;

  reaction_timer_if bus ();

  reaction_timer #(.MS_DIV(MS), .MIN_DELAY_MS(MIN), .RAND_BITS(RB), .LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference pseudo-random sequence, advanced once per clock like the game's generator.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart(input logic k);
    logic [15:0] l;
    l = m_lfsr;
    exp_delay = MIN + int'(l[RB-1:0]);
    bus.key = k;
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    checks++;
    if (bus.led !== 1'b0 || bus.det_end !== 1'b0 || bus.foul !== 1'b0 ||
        bus.timeout !== 1'b0 || bus.ctrl !== 16'h0000) begin
      errors++;
      $display("FAIL restart_clear led=%b det=%b foul=%b to=%b ctrl=%h expected all zero",
               bus.led, bus.det_end, bus.foul, bus.timeout, bus.ctrl);
    end
  endtask

  task automatic run_wait(input logic k);
    for (int i = 0; i < MS * exp_delay; i++) begin
      checks++;
      if (bus.led !== 1'b0 || bus.det_end !== 1'b0) begin
        errors++;
        $display("FAIL wait_dark i=%0d led=%b det=%b expected 0/0", i, bus.led, bus.det_end);
      end
      bus.key = k;
      step();
    end
    checks++;
    if (bus.led !== 1'b1) begin
      errors++;
      $display("FAIL led_rise delay=%0d led=%b expected 1", exp_delay, bus.led);
    end
  endtask

  // Steps through GO until the round ends plus a few DONE cycles (incl. a re-press).
  task automatic run_go(input int held_until, input int press_at, output logic [15:0] fin);
    logic pressed;
    int   end_s;
    pressed = (press_at >= 0) && (press_at < TO_STEPS);
    end_s   = pressed ? press_at + 1 : TO_STEPS;
    for (int s = 0; s <= end_s + 3; s++) begin
      logic [15:0] ec;
      logic el, ed, et;
      if (s < end_s) begin
        el = 1'b1; ed = 1'b0; et = 1'b0; ec = to_bcd(s / MS);
      end else begin
        el = 1'b0; ed = (s == end_s); et = !pressed;
        ec = pressed ? to_bcd(press_at / MS) : 16'h9999;
      end
      checks++;
      if (bus.led !== el || bus.det_end !== ed || bus.ctrl !== ec ||
          bus.timeout !== et || bus.foul !== 1'b0) begin
        errors++;
        $display("FAIL go s=%0d led=%b/%b det=%b/%b ctrl=%h/%h to=%b/%b foul=%b/0",
                 s, bus.led, el, bus.det_end, ed, bus.ctrl, ec, bus.timeout, et, bus.foul);
      end
      bus.key = (s < held_until) || (pressed && s >= press_at && s != end_s + 1) ||
                (!pressed && s == end_s + 2);
      step();
    end
    fin = bus.ctrl;
  endtask

  task automatic test_reset();
    bus.restart = 1'b0;
    bus.key = 1'b0;
    rst = 1'b1;
    step(); step();
    checks++;
    if (bus.led !== 1'b0 || bus.det_end !== 1'b0 || bus.ctrl !== 16'h0000 ||
        bus.foul !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state led=%b det=%b ctrl=%h foul=%b to=%b expected zeros",
               bus.led, bus.det_end, bus.ctrl, bus.foul, bus.timeout);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.key = i[1];
      step();
      checks++;
      if (bus.led !== 1'b0 || bus.det_end !== 1'b0 || bus.foul !== 1'b0 || bus.ctrl !== 16'h0000) begin
        errors++;
        $display("FAIL idle_key i=%0d led=%b det=%b foul=%b ctrl=%h expected idle",
                 i, bus.led, bus.det_end, bus.foul, bus.ctrl);
      end
    end
  endtask

  task automatic test_normal();
    do_restart(1'b0);
    run_wait(1'b0);
    run_go(0, 37 * MS, c);
    checks++;
    if (c !== 16'h0037) begin errors++; $display("FAIL normal_ctrl got=%h expected=0037", c); end
  endtask

  task automatic test_false_start();
    for (int r = 0; r < 4; r++) begin
      int w;
      do_restart(1'b0);
      w = (r == 0) ? MS * exp_delay - 1 : int'($urandom_range(0, MS * exp_delay - 1));
      for (int i = 0; i < w; i++) step();
      bus.key = 1'b1;
      step();
      checks++;
      if (bus.det_end !== 1'b1 || bus.foul !== 1'b1 || bus.ctrl !== 16'h0000 || bus.led !== 1'b0) begin
        errors++;
        $display("FAIL foul_end w=%0d det=%b foul=%b ctrl=%h led=%b expected 1/1/0000/0",
                 w, bus.det_end, bus.foul, bus.ctrl, bus.led);
      end
      step();
      bus.key = 1'b0;
      step();
      bus.key = 1'b1;
      for (int i = 0; i < 8 * MS; i++) begin
        step();
        checks++;
        if (bus.det_end !== 1'b0 || bus.led !== 1'b0 || bus.foul !== 1'b1) begin
          errors++;
          $display("FAIL foul_hold i=%0d det=%b led=%b foul=%b expected 0/0/1",
                   i, bus.det_end, bus.led, bus.foul);
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_restart(1'b0);
    run_wait(1'b0);
    run_go(0, -1, c);
    checks++;
    if (c !== 16'h9999 || bus.timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_end ctrl=%h to=%b expected 9999/1", c, bus.timeout);
    end
  endtask

  task automatic test_collisions();
    do_restart(1'b0);
    run_wait(1'b0);
    bus.key = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bus.led !== 1'b1) begin errors++; $display("FAIL coll_in_go led=%b expected 1", bus.led); end
    do_restart(1'b1);
    checks++;
    if (bus.det_end !== 1'b0 || bus.led !== 1'b0) begin
      errors++;
      $display("FAIL coll_restart det=%b led=%b expected 0/0", bus.det_end, bus.led);
    end
    run_wait(1'b1);
    run_go(3, 39, c);
    checks++;
    if (c !== 16'h0009) begin errors++; $display("FAIL coll_tick got=%h expected=0009", c); end
  endtask

  task automatic test_held_key();
    do_restart(1'b1);
    run_wait(1'b1);
    run_go(200, 1000 * MS + 1, c);
    checks++;
    if (c !== 16'h1000) begin errors++; $display("FAIL held_carry got=%h expected=1000", c); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int p, h;
      h = int'($urandom_range(0, 1)) * int'($urandom_range(1, 20));
      p = h + 1 + int'($urandom_range(0, 600));
      do_restart(h != 0);
      run_wait(h != 0);
      run_go(h, p, c);
      checks++;
      if (c !== to_bcd(p / MS)) begin
        errors++;
        $display("FAIL random_ctrl p=%0d got=%h expected=%h", p, c, to_bcd(p / MS));
      end
    end
  endtask

  task automatic test_rst_mid();
    do_restart(1'b0);
    run_wait(1'b0);
    for (int i = 0; i < 20; i++) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.led !== 1'b0 || bus.det_end !== 1'b0 || bus.ctrl !== 16'h0000 ||
        bus.foul !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid led=%b det=%b ctrl=%h foul=%b to=%b expected zeros",
               bus.led, bus.det_end, bus.ctrl, bus.foul, bus.timeout);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.key = i[0];
      step();
      checks++;
      if (bus.det_end !== 1'b0 || bus.led !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle i=%0d det=%b led=%b expected 0/0", i, bus.det_end, bus.led);
      end
    end
    do_restart(1'b0);
    run_wait(1'b0);
    run_go(0, 21, c);
  endtask

  initial begin
    bus.restart = 1'b0;
    bus.key = 1'b0;
    test_reset();
    test_normal();
    test_false_start();
    test_timeout();
    test_collisions();
    test_held_key();
    test_random();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Front end of the reaction-test game. Arms on `restart` and waits a pseudo-random delay, then lights the stimulus LED.
- Measures the player's key response time in milliseconds as 4-digit BCD.
- Delivers the result on `ctrl[15:0]` with a one-cycle `det_end` strobe, which is exactly the interface the seven-segment display block consumes.
- Also flags false starts (key pressed before the LED) and timeouts.

Parameters:
- MS_DIV, 50000, clk cycles per millisecond (50 MHz clock); must be at least 2.
- MIN_DELAY_MS, 1000, fixed part of the random pre-stimulus delay, in ms.
- RAND_BITS, 12, number of LFSR bits added to the delay (random part ranges 0..2^RAND_BITS-1 ms).
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-high.
- restart  in  1  synchronous, active-high; starts a new round from any state.
- key  in  1  player button, already debounced, active-high level.
- led  out  1  stimulus lamp; high while the reaction is being timed.
- det_end  out  1  one-cycle pulse when a round ends (result, foul or timeout).
- ctrl  out  16  result as BCD ms: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- foul  out  1  high from a false-start end until the next restart or rst.
- timeout  out  1  high from a saturated end until the next restart or rst.

Behaviour:
- Reset (async, rst=1): state IDLE; led=0, det_end=0, ctrl=16'h0000, foul=0, timeout=0; lfsr=LFSR_SEED; prescaler=0; delay counter=0; key_q=0.
- Key edge detection: key_q registers key every cycle; press = key & ~key_q. A key already held when a phase starts does not count until it is released and pressed again.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in all states. It is never all-zero.
- States: IDLE, WAIT, GO, DONE, FOUL.
- restart=1 (any state, highest priority after rst), next cycle:
  - state=WAIT, ctrl=0, led=0, foul=0, timeout=0, prescaler=0, det_end=0;
  - delay counter loaded with MIN_DELAY_MS + lfsr[RAND_BITS-1:0], sampled in the restart cycle.
- IDLE: outputs static; leaves only on restart.
- WAIT:
  - Prescaler counts 0..MS_DIV-1 and wraps; ms_tick is asserted in the cycle it equals MS_DIV-1.
  - On each ms_tick the delay counter decrements.
  - press in WAIT (not restart) -> next cycle FOUL: foul=1, det_end=1 for that one cycle, ctrl stays 0.
  - ms_tick with delay counter==1 and no press -> next cycle GO: led=1, prescaler=0, ctrl=0.
  - If press and the final ms_tick coincide, FOUL wins.
- GO:
  - Prescaler runs from 0; each ms_tick increments ctrl as BCD with ripple carry (digit 9 -> 0, carry to the next digit).
  - The first increment occurs MS_DIV cycles after led rises.
  - press -> next cycle DONE: led=0, det_end=1 for one cycle, ctrl frozen.
  - If press and ms_tick coincide, press wins and that tick's increment is dropped.
  - ms_tick with ctrl==16'h9999 -> no wrap: ctrl stays 9999, next cycle DONE, timeout=1, led=0, det_end=1.
- DONE / FOUL: ctrl, foul and timeout are held; det_end=0 after its single pulse; key is ignored; only restart leaves.
- Invariants:
  - det_end is exactly one cycle per round and never asserts twice without an intervening restart.
  - ctrl digits are always valid BCD (0..9).
  - led is high only in GO.
- Simultaneous events:
  - restart together with press: restart wins and the press is ignored.
  - rst mid-round: immediate IDLE and all outputs cleared; no det_end pulse.

Test Plan (MS_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2):
- Reset: rst pulse -> led=0, det_end=0, ctrl=16'h0000, foul=0, timeout=0, state IDLE; key presses ignored until restart.
- Normal round: restart, then key pressed exactly 37*4 cycles after led rises -> led falls next cycle, det_end high for 1 cycle, ctrl=16'h0037, foul=0.
- False start: restart, press during WAIT -> det_end 1 cycle, foul=1, ctrl=16'h0000, led never rises; a further press gives no second det_end.
- Timeout: restart, no press -> after 10000 ms ticks in GO, ctrl=16'h9999, timeout=1, det_end 1 cycle, led=0.
- Collisions:
  - restart and press in the same cycle during GO -> no det_end, state WAIT, ctrl=0.
  - Press coincident with the ms_tick taking ctrl 0009->0010 -> ctrl=16'h0009.
- Held key: key held high through restart and into GO -> no result until release and re-press; BCD carry check at 0099->0100 and 0999->1000.
